// File: rtl/rename_reg_file_pkg.sv
// Shared constants for the rename register file slice.
// Holds the default widths, the NULL ROB tag and the boolean and zero-word
// literals used by the top and by the read-port mux.
package rename_reg_file_pkg;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_REG_NUM = 32;
  localparam int unsigned DEF_TAG_W   = 4;

  // Tag value meaning "no pending producer"
  localparam int unsigned NULL_TAG = 0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DEF_XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/rename_reg_file_read_port.sv
// rrf_read_port: combinational operand read with commit bypass.
// Ports:
//   idx        register index being read
//   reg_value  stored value of register idx
//   reg_busy   rename-pending flag of register idx
//   reg_tag    producer tag of register idx
//   cmt_*      this cycle's commit ports, packed, port 0 in LSBs
//   v / q      operand value (0 when pending) / producer tag (NULL when ready)
module rrf_read_port
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned RW         = 5,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  parameter int unsigned NUM_COMMIT = 2
) (
  input  logic [RW-1:0]              idx,
  input  logic [XLEN-1:0]            reg_value,
  input  logic                       reg_busy,
  input  logic [TAG_W-1:0]           reg_tag,
  input  logic [NUM_COMMIT-1:0]      cmt_valid,
  input  logic [NUM_COMMIT*RW-1:0]   cmt_rd,
  input  logic [NUM_COMMIT*TAG_W-1:0] cmt_tag,
  input  logic [NUM_COMMIT*XLEN-1:0] cmt_data,
  output logic [XLEN-1:0]            v,
  output logic [TAG_W-1:0]           q
);

  logic            hit;
  logic [XLEN-1:0] hit_data;

  // Ascending scan so the youngest matching commit port wins.
  always_comb begin
    hit      = FALSE;
    hit_data = '0;
    for (int unsigned p = 0; p < NUM_COMMIT; p++) begin
      if (cmt_valid[p] && cmt_rd[p*RW +: RW] == idx &&
          cmt_tag[p*TAG_W +: TAG_W] == reg_tag) begin
        hit      = TRUE;
        hit_data = cmt_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    v = '0;
    q = TAG_W'(NULL_TAG);
    if (idx != '0) begin
      if (!reg_busy) begin
        v = reg_value;
      end else if (hit) begin
        v = hit_data;
      end else begin
        q = reg_tag;
      end
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with rename status.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   dis_valid_in/rd/tag       dispatch rename of rd to a ROB tag
//   rd_idx_in -> rd_V_out/rd_Q_out  NUM_READ combinational operand reads
//   cmt_valid/rd/tag/data_in  NUM_COMMIT commit ports (higher index younger)
//   flush_in                  discard all renames
//   err_out                   sticky: commit to a non-busy nonzero register
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned REG_NUM    = DEF_REG_NUM,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_COMMIT = 2,
  localparam int unsigned RW        = $clog2(REG_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dis_valid_in,
  input  logic [RW-1:0]                 dis_rd_in,
  input  logic [TAG_W-1:0]              dis_tag_in,
  input  logic [NUM_READ*RW-1:0]        rd_idx_in,
  output logic [NUM_READ*XLEN-1:0]      rd_V_out,
  output logic [NUM_READ*TAG_W-1:0]     rd_Q_out,
  input  logic [NUM_COMMIT-1:0]         cmt_valid_in,
  input  logic [NUM_COMMIT*RW-1:0]      cmt_rd_in,
  input  logic [NUM_COMMIT*TAG_W-1:0]   cmt_tag_in,
  input  logic [NUM_COMMIT*XLEN-1:0]    cmt_data_in,
  input  logic                          flush_in,
  output logic                          err_out
);

  logic [XLEN-1:0]  value [REG_NUM];
  logic             busy  [REG_NUM];
  logic [TAG_W-1:0] tag   [REG_NUM];

  logic [RW-1:0]    c_rd   [NUM_COMMIT];
  logic [TAG_W-1:0] c_tag  [NUM_COMMIT];
  logic [XLEN-1:0]  c_data [NUM_COMMIT];

  for (genvar p = 0; p < NUM_COMMIT; p++) begin : g_cmt
    assign c_rd[p]   = cmt_rd_in[p*RW +: RW];
    assign c_tag[p]  = cmt_tag_in[p*TAG_W +: TAG_W];
    assign c_data[p] = cmt_data_in[p*XLEN +: XLEN];
  end

  // Later nonblocking assignments win: younger commit ports override older
  // ones, and flush/dispatch override the commit-side busy clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        value[r] <= '0;
        busy[r]  <= FALSE;
        tag[r]   <= TAG_W'(NULL_TAG);
      end
      err_out <= FALSE;
    end else begin
      for (int unsigned p = 0; p < NUM_COMMIT; p++) begin
        if (cmt_valid_in[p] && c_rd[p] != '0) begin
          value[c_rd[p]] <= c_data[p];
          if (busy[c_rd[p]]) begin
            if (tag[c_rd[p]] == c_tag[p]) begin
              busy[c_rd[p]] <= FALSE;
              tag[c_rd[p]]  <= TAG_W'(NULL_TAG);
            end
          end else begin
            err_out <= TRUE;
          end
        end
      end
      if (flush_in) begin
        for (int unsigned r = 0; r < REG_NUM; r++) begin
          busy[r] <= FALSE;
          tag[r]  <= TAG_W'(NULL_TAG);
        end
      end else if (dis_valid_in && dis_rd_in != '0) begin
        busy[dis_rd_in] <= TRUE;
        tag[dis_rd_in]  <= dis_tag_in;
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [RW-1:0] idx;
    assign idx = rd_idx_in[i*RW +: RW];

    rrf_read_port #(
      .XLEN       (XLEN),
      .RW         (RW),
      .TAG_W      (TAG_W),
      .NUM_COMMIT (NUM_COMMIT)
    ) u_port (
      .idx       (idx),
      .reg_value (value[idx]),
      .reg_busy  (busy[idx]),
      .reg_tag   (tag[idx]),
      .cmt_valid (cmt_valid_in),
      .cmt_rd    (cmt_rd_in),
      .cmt_tag   (cmt_tag_in),
      .cmt_data  (cmt_data_in),
      .v         (rd_V_out[i*XLEN +: XLEN]),
      .q         (rd_Q_out[i*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_rename_reg_file.sv
module tb_rename_reg_file;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 4;
  localparam int unsigned RW   = 5;
  localparam int unsigned NR   = 2;
  localparam int unsigned NC   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               dis_valid_in;
  logic [RW-1:0]      dis_rd_in;
  logic [TW-1:0]      dis_tag_in;
  logic [NR*RW-1:0]   rd_idx_in;
  logic [NR*XLEN-1:0] rd_V_out;
  logic [NR*TW-1:0]   rd_Q_out;
  logic [NC-1:0]      cmt_valid_in;
  logic [NC*RW-1:0]   cmt_rd_in;
  logic [NC*TW-1:0]   cmt_tag_in;
  logic [NC*XLEN-1:0] cmt_data_in;
  logic               flush_in;
  logic               err_out;

  int errors = 0;
  int checks = 0;

  rename_reg_file #(
    .XLEN       (XLEN),
    .REG_NUM    (32),
    .TAG_W      (TW),
    .NUM_READ   (NR),
    .NUM_COMMIT (NC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dis_valid_in (dis_valid_in),
    .dis_rd_in    (dis_rd_in),
    .dis_tag_in   (dis_tag_in),
    .rd_idx_in    (rd_idx_in),
    .rd_V_out     (rd_V_out),
    .rd_Q_out     (rd_Q_out),
    .cmt_valid_in (cmt_valid_in),
    .cmt_rd_in    (cmt_rd_in),
    .cmt_tag_in   (cmt_tag_in),
    .cmt_data_in  (cmt_data_in),
    .flush_in     (flush_in),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] rv(input int unsigned i);
    return rd_V_out[i*XLEN +: XLEN];
  endfunction

  function automatic logic [TW-1:0] rq(input int unsigned i);
    return rd_Q_out[i*TW +: TW];
  endfunction

  task automatic idle();
    dis_valid_in = 1'b0;
    dis_rd_in    = '0;
    dis_tag_in   = '0;
    cmt_valid_in = '0;
    cmt_rd_in    = '0;
    cmt_tag_in   = '0;
    cmt_data_in  = '0;
    flush_in     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [RW-1:0] r, input logic [TW-1:0] t);
    dis_valid_in = 1'b1;
    dis_rd_in    = r;
    dis_tag_in   = t;
  endtask

  task automatic commit(input int unsigned p, input logic [RW-1:0] r,
                        input logic [TW-1:0] t, input logic [XLEN-1:0] d);
    cmt_valid_in[p]           = 1'b1;
    cmt_rd_in[p*RW +: RW]     = r;
    cmt_tag_in[p*TW +: TW]    = t;
    cmt_data_in[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input logic [RW-1:0] a, input logic [RW-1:0] b);
    rd_idx_in = {b, a};
  endtask

  task automatic hard_reset();
    idle();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    hard_reset();
    set_rd(5, 12);
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'h0) begin
      $display("FAIL reset_init: V=%h Q=%h want V=0 Q=0", rv(0), rq(0)); errors++;
    end
    // Build some state: x5 renamed, x12 committed while idle (sets err)
    dispatch(5, 7);
    commit(0, 12, 1, 32'h1234);
    tick();
    idle();
    #1;
    checks++;
    if (rq(0) !== 4'd7 || err_out !== 1'b1 || rv(1) !== 32'h1234) begin
      $display("FAIL reset_traffic: Q5=%h err=%b V12=%h want Q5=7 err=1 V12=1234",
               rq(0), err_out, rv(1)); errors++;
    end
    // Asynchronous reset between edges
    #1 rst = 1'b0;
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'h0 || rv(1) !== 32'h0 || rq(1) !== 4'h0
        || err_out !== 1'b0) begin
      $display("FAIL reset_async: V5=%h Q5=%h V12=%h Q12=%h err=%b want all 0",
               rv(0), rq(0), rv(1), rq(1), err_out); errors++;
    end
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    idle();
    dispatch(5, 3);
    set_rd(5, 0);
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'd3) begin
      $display("FAIL byp_pending: V=%h Q=%h want V=0 Q=3", rv(0), rq(0)); errors++;
    end
    commit(0, 5, 3, 32'hDEADBEEF);
    #1;
    checks++;
    if (rv(0) !== 32'hDEADBEEF || rq(0) !== 4'd0) begin
      $display("FAIL byp_same_cycle: V=%h Q=%h want V=deadbeef Q=0", rv(0), rq(0)); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'hDEADBEEF || rq(0) !== 4'd0 || err_out !== 1'b0) begin
      $display("FAIL byp_after: V=%h Q=%h err=%b want V=deadbeef Q=0 err=0",
               rv(0), rq(0), err_out); errors++;
    end
  endtask

  task automatic test_rename_chain();
    idle();
    set_rd(7, 0);
    dispatch(7, 2);
    tick();
    dispatch(7, 5);
    tick();
    idle();
    commit(0, 7, 2, 32'h11);
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'd5) begin
      $display("FAIL chain_no_bypass: V=%h Q=%h want V=0 Q=5", rv(0), rq(0)); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'd5 || err_out !== 1'b0) begin
      $display("FAIL chain_old_commit: V=%h Q=%h err=%b want V=0 Q=5 err=0",
               rv(0), rq(0), err_out); errors++;
    end
    commit(1, 7, 5, 32'h22);
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'h22 || rq(0) !== 4'd0) begin
      $display("FAIL chain_final: V=%h Q=%h want V=22 Q=0", rv(0), rq(0)); errors++;
    end
  endtask

  task automatic test_commit_order();
    idle();
    set_rd(0, 9);
    dispatch(9, 6);
    tick();
    idle();
    commit(0, 9, 4, 32'd1);
    commit(1, 9, 6, 32'd2);
    #1;
    checks++;
    if (rv(1) !== 32'd2 || rq(1) !== 4'd0) begin
      $display("FAIL order_bypass: V=%h Q=%h want V=2 Q=0", rv(1), rq(1)); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv(1) !== 32'd2 || rq(1) !== 4'd0 || err_out !== 1'b0) begin
      $display("FAIL order_after: V=%h Q=%h err=%b want V=2 Q=0 err=0",
               rv(1), rq(1), err_out); errors++;
    end
    // Matching tag on the older port; younger port still owns the value write
    dispatch(9, 6);
    tick();
    idle();
    commit(0, 9, 6, 32'd3);
    commit(1, 9, 4, 32'd4);
    #1;
    checks++;
    if (rv(1) !== 32'd3 || rq(1) !== 4'd0) begin
      $display("FAIL order_old_match: V=%h Q=%h want V=3 Q=0", rv(1), rq(1)); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv(1) !== 32'd4 || rq(1) !== 4'd0) begin
      $display("FAIL order_young_value: V=%h Q=%h want V=4 Q=0", rv(1), rq(1)); errors++;
    end
  endtask

  task automatic test_flush();
    idle();
    set_rd(3, 4);
    dispatch(3, 1);
    commit(0, 3, 1, 32'h33);
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'd0) begin
      $display("FAIL flush_pre_rename: V=%h Q=%h want V=0 Q=0", rv(0), rq(0)); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'd1 || err_out !== 1'b1) begin
      $display("FAIL flush_rename_wins: V=%h Q=%h err=%b want V=0 Q=1 err=1",
               rv(0), rq(0), err_out); errors++;
    end
    flush_in = 1'b1;
    dispatch(4, 2);
    #1;
    checks++;
    if (rq(0) !== 4'd1 || rq(1) !== 4'd0) begin
      $display("FAIL flush_pre_state: Q3=%h Q4=%h want Q3=1 Q4=0", rq(0), rq(1)); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'h33 || rq(0) !== 4'd0 || rv(1) !== 32'h0 || rq(1) !== 4'd0) begin
      $display("FAIL flush_after: V3=%h Q3=%h V4=%h Q4=%h want V3=33 Q3=0 V4=0 Q4=0",
               rv(0), rq(0), rv(1), rq(1)); errors++;
    end
  endtask

  task automatic test_err();
    hard_reset();
    set_rd(0, 10);
    checks++;
    if (err_out !== 1'b0) begin
      $display("FAIL err_cleared: err=%b want 0", err_out); errors++;
    end
    commit(0, 0, 3, 32'hFF);
    dispatch(0, 3);
    tick();
    idle();
    #1;
    checks++;
    if (rv(0) !== 32'h0 || rq(0) !== 4'd0 || err_out !== 1'b0) begin
      $display("FAIL err_x0: V=%h Q=%h err=%b want V=0 Q=0 err=0",
               rv(0), rq(0), err_out); errors++;
    end
    commit(1, 10, 5, 32'hA5);
    #1;
    checks++;
    if (err_out !== 1'b0) begin
      $display("FAIL err_pre_edge: err=%b want 0", err_out); errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (err_out !== 1'b1 || rv(1) !== 32'hA5 || rq(1) !== 4'd0) begin
      $display("FAIL err_set: err=%b V10=%h Q10=%h want err=1 V10=a5 Q10=0",
               err_out, rv(1), rq(1)); errors++;
    end
    tick();
    tick();
    checks++;
    if (err_out !== 1'b1) begin
      $display("FAIL err_sticky: err=%b want 1", err_out); errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err_out !== 1'b0) begin
      $display("FAIL err_reset: err=%b want 0", err_out); errors++;
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rd_idx_in = '0;
    idle();
    test_reset();
    test_bypass();
    test_rename_chain();
    test_commit_order();
    test_flush();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
